// File: rtl/mod3_pkg.sv
// Shared mod-3 types and helpers for the serializer and the serial checker.
// A frame value is divisible by 3 when its MSB-first running remainder ends at 0.
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef logic [1:0] rem_t;

  // Running remainder after appending one bit: (2*rem + b) mod 3.
  function automatic rem_t mod3_next(input rem_t rem, input logic b);
    rem_t nxt;
    case ({rem, b})
      3'b000:  nxt = 2'd0;
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b011:  nxt = 2'd0;
      3'b100:  nxt = 2'd1;
      3'b101:  nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // Two appended bits multiply the payload by 4 (== 1 mod 3), so chk = (3 - rem) mod 3.
  function automatic logic [1:0] mod3_chk(input rem_t rem);
    logic [1:0] chk;
    case (rem)
      2'd0:    chk = 2'b00;
      2'd1:    chk = 2'b10;
      2'd2:    chk = 2'b01;
      default: chk = 2'b00;
    endcase
    return chk;
  endfunction

endpackage

// File: rtl/mod3_check_serializer_if.sv
// Payload-in and serial-out handshakes of the mod-3 check serializer.
interface mod3_check_serializer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_bit;
  logic              tx_sof;
  logic              tx_eof;

  modport slave (
    input  in_valid, in_data, tx_ready,
    output in_ready, tx_valid, tx_bit, tx_sof, tx_eof
  );

  modport master (
    output in_valid, in_data, tx_ready,
    input  in_ready, tx_valid, tx_bit, tx_sof, tx_eof
  );
endinterface

// File: rtl/mod3_rem_tracker.sv
// Registered mod-3 remainder of the bits shifted so far; clr wins over en.
module mod3_rem_tracker
  import mod3_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output rem_t rem
);

  rem_t rem_r;

  // Remainder register: cleared on frame accept, advanced on each payload beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_r <= 2'd0;
    end else if (clr) begin
      rem_r <= 2'd0;
    end else if (en) begin
      rem_r <= mod3_next(rem_r, bit_in);
    end else begin
      rem_r <= rem_r;
    end
  end

  assign rem = rem_r;

endmodule

// File: rtl/mod3_check_serializer.sv
// Serializes a payload word MSB-first and appends a 2-bit code that makes the
// whole frame value divisible by 3.
module mod3_check_serializer
  import mod3_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  mod3_check_serializer_if.slave  bus,
  output logic                    busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_r;
  logic [DATA_W-1:0] shreg_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              chk_lo_r;
  logic              tx_valid_r;
  logic              tx_bit_r;
  logic              tx_sof_r;
  logic              tx_eof_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              data_beat_s;
  logic [DATA_W-1:0] shreg_shift_s;
  rem_t              rem_s;
  rem_t              rem_next_s;
  logic [1:0]        chk_next_s;

  // Held in reset the block must not consume a word even though state reads IDLE.
  assign in_ready_s    = resetn && (state_r == IDLE);
  assign accept_s      = bus.in_valid && in_ready_s;
  assign data_beat_s   = (state_r == DATA) && tx_valid_r && bus.tx_ready;
  assign shreg_shift_s = shreg_r << 1;
  assign rem_next_s    = mod3_next(rem_s, shreg_r[DATA_W-1]);
  assign chk_next_s    = mod3_chk(rem_next_s);

  mod3_rem_tracker u_rem (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept_s),
    .en     (data_beat_s),
    .bit_in (shreg_r[DATA_W-1]),
    .rem    (rem_s)
  );

  // Frame FSM: owns the shift register, beat counter and all serial outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= IDLE;
      shreg_r    <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      chk_lo_r   <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_bit_r   <= 1'b0;
      tx_sof_r   <= 1'b0;
      tx_eof_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= DATA;
            shreg_r    <= bus.in_data;
            cnt_r      <= {CNT_W{1'b0}};
            tx_valid_r <= 1'b1;
            tx_bit_r   <= bus.in_data[DATA_W-1];
            tx_sof_r   <= 1'b1;
            tx_eof_r   <= 1'b0;
          end
        end
        DATA: begin
          if (bus.tx_ready) begin
            shreg_r  <= shreg_shift_s;
            cnt_r    <= cnt_r + CNT_W'(1);
            tx_sof_r <= 1'b0;
            if (cnt_r == LAST_CNT) begin
              state_r  <= CHECK;
              chk_lo_r <= chk_next_s[0];
              tx_bit_r <= chk_next_s[1];
            end else begin
              tx_bit_r <= shreg_shift_s[DATA_W-1];
            end
          end
        end
        CHECK: begin
          if (bus.tx_ready) begin
            if (tx_eof_r) begin
              state_r    <= IDLE;
              tx_valid_r <= 1'b0;
              tx_bit_r   <= 1'b0;
              tx_eof_r   <= 1'b0;
            end else begin
              tx_bit_r <= chk_lo_r;
              tx_eof_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          tx_valid_r <= 1'b0;
          tx_bit_r   <= 1'b0;
          tx_sof_r   <= 1'b0;
          tx_eof_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_bit   = tx_bit_r;
  assign bus.tx_sof   = tx_sof_r;
  assign bus.tx_eof   = tx_eof_r;
  assign busy         = (state_r != IDLE);

endmodule
